// File: rtl/edge_pkg.sv
// Shared mode encoding for the multi-channel edge-event detector.
package edge_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    // Bit 0 of the mode enables rising edges.
    function automatic logic mode_has_rise(input edge_mode_t mode);
        return mode[0];
    endfunction

    // Bit 1 of the mode enables falling edges.
    function automatic logic mode_has_fall(input edge_mode_t mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, glitch filter, edge detector, sticky flag
// and saturating event counter.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sig_in,
    input  edge_mode_t        mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              clr,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic              sticky,
    output logic [CNT_W-1:0]  evt_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FILT_W-1:0] FILT_ONE = FILT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   stable;
    logic [FILT_W-1:0]      fcnt;
    logic                   expire;
    logic                   rise_qual;
    logic                   fall_qual;
    logic                   evt;

    assign s = sync_q[SYNC_STAGES-1];

    // A lowered filt_len can leave fcnt above it, so ">=" rather than "=="
    // guarantees the filter still expires.
    assign expire    = (s != stable) && (fcnt >= filt_len);
    assign rise_qual = expire &&  s && mode_has_rise(mode);
    assign fall_qual = expire && !s && mode_has_fall(mode);
    assign evt       = rise_qual || fall_qual;

    // Plain shift register synchroniser, nothing between the stages.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // pre-edge values, independent of block ordering.
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end

    // Glitch filter: accept a new level after it persists filt_len+1 cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            fcnt   <= '0;
        end else if (s == stable) begin
            fcnt   <= '0;
        end else if (expire) begin
            stable <= s;
            fcnt   <= '0;
        end else begin
            fcnt   <= fcnt + FILT_ONE;
        end
    end

    // Registered one-cycle pulses, high in the cycle stable changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise_qual;
            fall_pulse <= fall_qual;
        end
    end

    // Sticky flag and saturating counter; a qualified edge beats clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky  <= 1'b0;
            evt_cnt <= '0;
        end else if (evt) begin
            sticky <= 1'b1;
            if (clr)                   evt_cnt <= CNT_ONE;
            else if (evt_cnt != CNT_MAX) evt_cnt <= evt_cnt + CNT_ONE;
        end else if (clr) begin
            sticky  <= 1'b0;
            evt_cnt <= '0;
        end
    end

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge-event detector: replicates edge_chan per channel,
// packs the per-channel results and ORs the sticky flags into irq.
module edge_event_unit
    import edge_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [FILT_W-1:0]     filt_len,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       rise_pulse,
    output logic [N_CH-1:0]       fall_pulse,
    output logic [N_CH-1:0]       sticky,
    output logic [N_CH*CNT_W-1:0] evt_cnt,
    output logic                  irq
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_W     (FILT_W),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .sig_in    (sig_in[i]),
            .mode      (edge_mode_t'(mode[2*i +: 2])),
            .filt_len  (filt_len),
            .clr       (clr[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
            .sticky    (sticky[i]),
            .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

    // irq is sourced purely from sticky flops, so it cannot glitch on inputs.
    assign irq = |sticky;

endmodule

// File: tb/tb_edge_event_unit.sv
// Self-checking bench for edge_event_unit: directed scenarios plus random
// traffic, all compared every cycle against a behavioural model.
module tb_edge_event_unit;
    import edge_pkg::*;

    localparam int N_CH   = 4;
    localparam int SYNC   = 2;
    localparam int FILT_W = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [N_CH-1:0]       sig_in;
    logic [2*N_CH-1:0]     mode;
    logic [FILT_W-1:0]     filt_len;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       rise_pulse;
    logic [N_CH-1:0]       fall_pulse;
    logic [N_CH-1:0]       sticky;
    logic [N_CH*CNT_W-1:0] evt_cnt;
    logic                  irq;

    int n_checks = 0;
    int n_fail   = 0;

    edge_event_unit #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .mode(mode),
        .filt_len(filt_len), .clr(clr), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .sticky(sticky), .evt_cnt(evt_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: pipeline of sampled input, count of consecutive
    // cycles the synchronised level disagrees with the accepted level.
    bit m_hist   [N_CH][SYNC];
    bit m_level  [N_CH];
    int m_diff   [N_CH];
    bit m_rise   [N_CH];
    bit m_fall   [N_CH];
    bit m_sticky [N_CH];
    int m_cnt    [N_CH];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int j = 0; j < SYNC; j++) m_hist[c][j] = 1'b0;
                m_level[c] = 0; m_diff[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
                m_sticky[c] = 0; m_cnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                bit sv;
                bit changed;
                sv = m_hist[c][SYNC-1];
                changed = 1'b0;
                if (sv == m_level[c]) begin
                    m_diff[c] = 0;
                end else if (m_diff[c] + 1 > int'(filt_len)) begin
                    changed = 1'b1;
                    m_level[c] = sv;
                    m_diff[c] = 0;
                end else begin
                    m_diff[c] = m_diff[c] + 1;
                end
                m_rise[c] = changed &&  sv && mode[2*c];
                m_fall[c] = changed && !sv && mode[2*c+1];
                if (m_rise[c] || m_fall[c]) begin
                    m_sticky[c] = 1'b1;
                    if (clr[c]) m_cnt[c] = 1;
                    else if (m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
                end else if (clr[c]) begin
                    m_sticky[c] = 1'b0;
                    m_cnt[c] = 0;
                end
                for (int j = SYNC - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
                m_hist[c][0] = sig_in[c];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0]       e_rise, e_fall, e_sticky;
        logic [N_CH*CNT_W-1:0] e_cnt;
        for (int c = 0; c < N_CH; c++) begin
            e_rise[c]   = m_rise[c];
            e_fall[c]   = m_fall[c];
            e_sticky[c] = m_sticky[c];
            e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        check("rise_pulse", 64'(rise_pulse), 64'(e_rise));
        check("fall_pulse", 64'(fall_pulse), 64'(e_fall));
        check("sticky",     64'(sticky),     64'(e_sticky));
        check("evt_cnt",    64'(evt_cnt),    64'(e_cnt));
        check("irq",        64'(irq),        64'(|e_sticky));
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic set_mode(input int ch, input edge_mode_t m);
        mode[2*ch +: 2] = m;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return evt_cnt[ch*CNT_W +: CNT_W];
    endfunction

    initial begin
        reset_n = 1'b0; sig_in = '0; mode = '0; filt_len = '0; clr = '0;
        tick(3);
        reset_n = 1'b1;
        set_mode(0, MODE_RISE);
        tick(3);

        // 1: L=0 rising edge on ch0, pulse after SYNC+L+1 sample edges
        sig_in[0] = 1'b1;
        tick(2);
        check("t1_no_early_pulse", 64'(rise_pulse[0]), 64'd0);
        tick(1);
        check("t1_rise", 64'(rise_pulse[0]), 64'd1);
        check("t1_sticky", 64'(sticky[0]), 64'd1);
        check("t1_cnt", 64'(cnt_of(0)), 64'd1);
        check("t1_irq", 64'(irq), 64'd1);
        tick(1);
        check("t1_one_cycle", 64'(rise_pulse[0]), 64'd0);

        // 2: L=3, glitch of 3 cycles ignored, 4-cycle level accepted
        filt_len = 4'd3;
        set_mode(1, MODE_BOTH);
        sig_in[1] = 1'b1; tick(3);
        sig_in[1] = 1'b0; tick(8);
        check("t2_glitch_ignored", 64'(cnt_of(1)), 64'd0);
        sig_in[1] = 1'b1; tick(4);
        sig_in[1] = 1'b0; tick(10);
        check("t2_rise_fall_cnt", 64'(cnt_of(1)), 64'd2);

        // 3: fall-only mode, then off mode
        filt_len = 4'd0;
        set_mode(2, MODE_FALL);
        sig_in[2] = 1'b1; tick(5);
        sig_in[2] = 1'b0; tick(5);
        check("t3_fall_only_cnt", 64'(cnt_of(2)), 64'd1);
        set_mode(2, MODE_OFF);
        sig_in[2] = 1'b1; tick(5);
        sig_in[2] = 1'b0; tick(5);
        check("t3_off_cnt_held", 64'(cnt_of(2)), 64'd1);

        // 4: counter saturation on ch3, then clear everything
        set_mode(3, MODE_BOTH);
        for (int i = 0; i < 300; i++) begin
            sig_in[3] = ~sig_in[3];
            tick(2);
        end
        tick(5);
        check("t4_saturated", 64'(cnt_of(3)), 64'(CNT_MAX));
        clr = '1; tick(1); clr = '0; tick(1);
        check("t4_clr_cnt", 64'(cnt_of(3)), 64'd0);
        check("t4_clr_sticky", 64'(sticky), 64'd0);
        check("t4_irq_low", 64'(irq), 64'd0);

        // 5: clr coincident with qualified rise on ch0 -> edge wins
        sig_in[0] = 1'b0; tick(5);
        sig_in[0] = 1'b1; tick(2);
        clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
        check("t5_rise", 64'(rise_pulse[0]), 64'd1);
        check("t5_sticky", 64'(sticky[0]), 64'd1);
        check("t5_cnt", 64'(cnt_of(0)), 64'd1);

        // 6: async reset mid-filter, input high at release gives one rise
        filt_len = 4'd7;
        sig_in[0] = 1'b0; tick(4);
        reset_n = 1'b0;
        #1;
        check("t6_rst_sticky", 64'(sticky), 64'd0);
        check("t6_rst_cnt", 64'(evt_cnt), 64'd0);
        check("t6_rst_irq", 64'(irq), 64'd0);
        check("t6_rst_pulses", 64'({rise_pulse, fall_pulse}), 64'd0);
        tick(2);
        sig_in[0] = 1'b1;
        filt_len = 4'd0;
        reset_n = 1'b1;
        tick(6);
        check("t6_rise_after_release", 64'(cnt_of(0)), 64'd1);
        check("t6_sticky_after_release", 64'(sticky[0]), 64'd1);

        // Random traffic with occasional mode, filter length and clr changes
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(9) < 3) sig_in[c] = ~sig_in[c];
            if ($urandom_range(49) == 0) mode = (2*N_CH)'($urandom);
            if ($urandom_range(99) == 0) filt_len = FILT_W'($urandom_range(3));
            clr = ($urandom_range(19) == 0) ? N_CH'($urandom) : '0;
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
